alu_muldiv: RTL and testbench

- Next-generation EX-stage ALU for the pipelined MIPS datapath, parametrised in WIDTH.
- Single-cycle ops: add, sub, and, or, slt, sltu, xor, nor.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, plus a busy handshake that the hazard unit uses to stall the pipeline.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/muldiv_iter.sv | 132 +++++++++++++
 rtl/alu_muldiv.sv | 100 ++++++++++
 tb/tb_alu_muldiv.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the EX-stage ALU with iterative mul/div.
// Optional overflow detection in alu_muldiv is enabled by ALU_OVERFLOW_EN.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_SLTU  = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_NOR   = 4'b0111;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIV   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_MTHI  = 4'b1100;
  localparam logic [3:0] ALU_MTLO  = 4'b1101;
  localparam logic [3:0] ALU_MFHI  = 4'b1110;
  localparam logic [3:0] ALU_MFLO  = 4'b1111;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_e;

  function automatic logic is_muldiv(input logic [3:0] ctr);
    return ctr[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiplier / restoring divider on operand magnitudes.
// Produces a one-cycle write strobe with the sign-corrected HI/LO results.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,      // [1]=divide, [0]=unsigned
  input  logic             launch,
  input  logic             flush,
  output logic             busy,
  output logic             wr,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  import alu_pkg::*;

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d, a_raw_q, a_raw_d;
  logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic             div0_q, div0_d, is_div_q, is_div_d;

  logic             sgn;
  logic [WIDTH-1:0] a_mag, b_mag, diff, quo, rem;
  logic [WIDTH:0]   mul_sum, rem_shift;
  logic [2*WIDTH-1:0] prod;

  assign sgn   = ~op[0];
  assign a_mag = (sgn && A[WIDTH-1]) ? -A : A;
  assign b_mag = (sgn && B[WIDTH-1]) ? -B : B;

  assign mul_sum   = {1'b0, acc_q} + ({(WIDTH+1){lo_q[0]}} & {1'b0, opnd_q});
  assign rem_shift = {acc_q, lo_q[WIDTH-1]};
  // Remainder after a successful subtract is below the divisor, so WIDTH bits suffice.
  assign diff      = rem_shift[WIDTH-1:0] - opnd_q;

  assign prod = quo_neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
  assign quo  = quo_neg_q ? -lo_q : lo_q;
  assign rem  = rem_neg_q ? -acc_q : acc_q;

  assign busy   = (state_q != ST_IDLE);
  assign res_hi = is_div_q ? (div0_q ? a_raw_q : rem) : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div_q ? (div0_q ? '1 : quo) : prod[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    wr        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d   = op[1] ? ST_DIV : ST_MUL;
          cnt_d     = CW'(WIDTH - 1);
          acc_d     = '0;
          lo_d      = a_mag;
          opnd_d    = b_mag;
          a_raw_d   = A;
          quo_neg_d = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
          rem_neg_d = sgn & A[WIDTH-1];
          div0_d    = (B == '0);
          is_div_d  = op[1];
        end
      end
      ST_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DIV: begin
        if (rem_shift >= {1'b0, opnd_q}) begin
          acc_d = diff;
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_shift[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        wr      = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      wr      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: single-cycle ops, HI/LO registers and iterative mul/div with busy stall.
// Define ALU_OVERFLOW_EN to enable signed add/sub overflow detection.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUctr,
  input  logic             start,
  input  logic             flush,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import alu_pkg::*;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, sum, dif, res_hi, res_lo;
  logic             launch, wr;

  assign sum    = A + B;
  assign dif    = A - B;
  assign launch = start & ~busy & ~flush & is_muldiv(ALUctr);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .op     (ALUctr[1:0]),
    .launch (launch),
    .flush  (flush),
    .busy   (busy),
    .wr     (wr),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wr) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (start && !busy) begin
      if (ALUctr == ALU_MTHI) hi_d = A;
      if (ALUctr == ALU_MTLO) lo_d = A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

  always_comb begin
    Result = '0;
    unique case (ALUctr)
      ALU_ADD:  Result = sum;
      ALU_SUB:  Result = dif;
      ALU_AND:  Result = A & B;
      ALU_OR:   Result = A | B;
      ALU_SLT:  Result = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      ALU_SLTU: Result = {{(WIDTH-1){1'b0}}, A < B};
      ALU_XOR:  Result = A ^ B;
      ALU_NOR:  Result = ~(A | B);
      ALU_MFHI: Result = hi_q;
      ALU_MFLO: Result = lo_q;
      default:  Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

`ifdef ALU_OVERFLOW_EN
  always_comb begin
    Overflow = 1'b0;
    if (ALUctr == ALU_ADD) begin
      Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    end else if (ALUctr == ALU_SUB) begin
      Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
    end
  end
`else
  assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: vector table for single-cycle ops plus mul/div sequences.
module tb_alu_muldiv;
  import alu_pkg::*;

`ifdef ALU_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic        clk, rst_n, start, flush;
  logic [31:0] op_a, op_b;
  logic [3:0]  alu_ctr;
  logic [31:0] result, hi, lo;
  logic        zero, overflow, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctr;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[14];

  alu_muldiv #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (op_a),
    .B        (op_b),
    .ALUctr   (alu_ctr),
    .start    (start),
    .flush    (flush),
    .Result   (result),
    .Zero     (zero),
    .Overflow (overflow),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("launch_idle", {31'b0, busy}, 32'd0);
    op_a    = a;
    op_b    = b;
    alu_ctr = ctr;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [3:0] ctr, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    launch(ctr, a, b);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check({name, "_busy_cycles"}, n, 32'd33);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
    alu_ctr = ALU_MFHI;
    #1 check({name, "_mfhi"}, result, exp_hi);
    alu_ctr = ALU_MFLO;
    #1 check({name, "_mflo"}, result, exp_lo);
  endtask

  initial begin
    clk     = 1'b0;
    rst_n   = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    op_a    = '0;
    op_b    = '0;
    alu_ctr = ALU_ADD;

    vecs[0]  = '{32'd5,        32'd3,        ALU_ADD,  32'd8,        1'b0, 1'b0};
    vecs[1]  = '{32'd7,        32'd7,        ALU_SUB,  32'd0,        1'b1, 1'b0};
    vecs[2]  = '{32'hFFFFFFFF, 32'd1,        ALU_SLT,  32'd1,        1'b0, 1'b0};
    vecs[3]  = '{32'hFFFFFFFF, 32'd1,        ALU_SLTU, 32'd0,        1'b1, 1'b0};
    vecs[4]  = '{32'd0,        32'd0,        ALU_NOR,  32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[5]  = '{32'hF0F0F0F0, 32'hFF00FF00, ALU_AND,  32'hF000F000, 1'b0, 1'b0};
    vecs[6]  = '{32'hF0F0F0F0, 32'h0F0F0000, ALU_OR,   32'hFFFFF0F0, 1'b0, 1'b0};
    vecs[7]  = '{32'hF0F0F0F0, 32'hFF00FF00, ALU_XOR,  32'h0FF00FF0, 1'b0, 1'b0};
    vecs[8]  = '{32'h7FFFFFFF, 32'd1,        ALU_ADD,  32'h80000000, 1'b0, OVF_EN};
    vecs[9]  = '{32'h80000000, 32'd1,        ALU_SUB,  32'h7FFFFFFF, 1'b0, OVF_EN};
    vecs[10] = '{32'hFFFFFFFF, 32'd1,        ALU_ADD,  32'd0,        1'b1, 1'b0};
    vecs[11] = '{32'd12,       32'd34,       ALU_MULT, 32'd0,        1'b1, 1'b0};
    vecs[12] = '{32'd12,       32'd34,       ALU_MTHI, 32'd0,        1'b1, 1'b0};
    vecs[13] = '{32'd0,        32'd0,        ALU_MFHI, 32'd0,        1'b1, 1'b0};

    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      op_a    = vecs[i].a;
      op_b    = vecs[i].b;
      alu_ctr = vecs[i].ctr;
      #1;
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      check($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].zero});
      check($sformatf("vec%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].ovf});
    end

    run_op("mult_neg", ALU_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu", ALU_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
    run_op("div_neg", ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_zero", ALU_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    run_op("div_ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Flush at busy cycle 10 must leave the mthi/mtlo values in place.
    @(negedge clk);
    op_a = 32'h1234; alu_ctr = ALU_MTHI; start = 1'b1;
    @(negedge clk);
    op_a = 32'h5678; alu_ctr = ALU_MTLO;
    @(negedge clk);
    start = 1'b0;
    check("mthi", hi, 32'h1234);
    check("mtlo", lo, 32'h5678);
    launch(ALU_DIV, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    check("flush_busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy_after", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_busy_late", {31'b0, busy}, 32'd0);
    check("flush_hi", hi, 32'h1234);
    check("flush_lo", lo, 32'h5678);

    // Asynchronous reset in the middle of a multiply.
    launch(ALU_MULT, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    check("midrst_busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mult_after_rst", ALU_MULT, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
